// File: rtl/port_link.sv
`default_nettype none
// ============================================================================
//  Module      : port_link
//  Description : Single-word blocking channel between two neighbouring
//                compute nodes. A write completes only after the neighbour
//                has read the value; a read stalls until a value is present.
//                rd_data feeds the register file's input_val on port reads.
//
//  Ports       : clk       in   system clock, rising edge
//                reset     in   synchronous active-high reset (ignores clk_en)
//                clk_en    in   node step enable; state advances only when 1
//                wr_req    in   writer wants to send wr_data
//                wr_data   in   [WIDTH-1:0] value being sent
//                wr_stall  out  writer must hold its instruction
//                rd_req    in   reader wants a value
//                rd_data   out  [WIDTH-1:0] buffered value (registered)
//                rd_stall  out  reader must hold its instruction
//                full      out  debug: value buffered and not yet read
//
//  Revision    : 1.0  initial release
// ============================================================================
module port_link #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_stall,
    input  logic             rd_req,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_stall,
    output logic             full
);

    // Transfer handshake states.
    //   IDLE : no value held, waiting for a writer
    //   FULL : value held, waiting for the reader
    //   DONE : reader has taken the value; writer completes this cycle
    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_FULL = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_buf;
    logic [WIDTH-1:0] w_buf_nxt;

    // ------------------------------------------------------------------
    // State and buffer registers. Reset wins over the step enable so a
    // node can be cleared even while it is frozen.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_buf   <= '0;
        end else if (clk_en) begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        case (r_state)
            c_S_IDLE: begin
                if (wr_req) begin
                    w_buf_nxt   = wr_data;
                    w_state_nxt = c_S_FULL;
                end
            end
            c_S_FULL: begin
                // A writer dropping wr_req here is illegal but harmless:
                // the buffered value stays readable until consumed.
                if (rd_req) begin
                    w_state_nxt = c_S_DONE;
                end
            end
            c_S_DONE: begin
                w_state_nxt = c_S_IDLE;
            end
            default: begin
                // Unreachable encoding: recover to a clean empty channel.
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. The writer is released only in DONE, i.e. after the reader
    // has consumed the value; the reader is released only while FULL, so
    // there is no same-cycle bypass from wr_data to rd_data.
    // ------------------------------------------------------------------
    assign wr_stall = wr_req & (r_state != c_S_DONE);
    assign rd_stall = rd_req & (r_state != c_S_FULL);
    assign full     = (r_state == c_S_FULL);
    assign rd_data  = r_buf;

endmodule
`default_nettype wire
